// File: rtl/handshake_source_ctrl.sv
// ============================================================================
// handshake_source_ctrl : source side of a four-phase req/ack CDC handshake
// Revision 1.0
// ============================================================================
`default_nettype none

module handshake_source_ctrl #(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   ack_sync,
  output logic                   req,
  output logic [WIDTH-1:0]       xfer_data,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] xfer_count,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    ACK_LO = 2'd2
  } state_t;

  localparam int                WAIT_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(TIMEOUT_CYCLES);
  localparam bit                TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_t                   state_q, state_d;
  logic                     req_q, req_d;
  logic [WIDTH-1:0]         xfer_data_q, xfer_data_d;
  logic [COUNT_WIDTH-1:0]   xfer_count_q, xfer_count_d;
  logic [WAIT_W-1:0]        wait_q, wait_d;
  logic                     timeout_err_q, timeout_err_d;

  // A stale ack left over from before reset must fall before a new word is taken.
  assign in_ready    = (state_q == IDLE) && !ack_sync && !reset;
  assign req         = req_q;
  assign xfer_data   = xfer_data_q;
  assign busy        = (state_q != IDLE);
  assign xfer_count  = xfer_count_q;
  assign timeout_err = timeout_err_q;

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    xfer_data_d   = xfer_data_q;
    xfer_count_d  = xfer_count_q;
    wait_d        = wait_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          xfer_data_d = in_data;
          req_d       = 1'b1;
          state_d     = REQ_HI;
        end
      end
      REQ_HI: begin
        if (ack_sync) begin
          req_d        = 1'b0;
          xfer_count_d = xfer_count_q + COUNT_WIDTH'(1);
          state_d      = ACK_LO;
        end
      end
      ACK_LO: begin
        if (!ack_sync) begin
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    // Stall detection only flags; the handshake itself is never abandoned.
    if (state_d != state_q) begin
      wait_d = '0;
    end else if ((state_q != IDLE) && (wait_q != WAIT_MAX)) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    if (TIMEOUT_EN && (state_d == state_q) && (state_q != IDLE) && (wait_d == WAIT_MAX)) begin
      timeout_err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      req_q         <= 1'b0;
      xfer_data_q   <= '0;
      xfer_count_q  <= '0;
      wait_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      xfer_data_q   <= xfer_data_d;
      xfer_count_q  <= xfer_count_d;
      wait_q        <= wait_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule

`default_nettype wire
